// File: rtl/time_counter_pkg.sv
// time_counter_pkg: BCD limits, chime window start and BCD helpers shared by the clock.
package time_counter_pkg;
  localparam logic [7:0] SEC_MAX     = 8'h59;
  localparam logic [7:0] MIN_MAX     = 8'h59;
  localparam logic [7:0] HOUR_MAX    = 8'h23;
  localparam logic [7:0] CHIME_START = 8'h55;
  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    return (v[3:0] == 4'd9) ? {v[7:4] + 4'd1, 4'd0} : v + 8'd1;
  endfunction
  // Digits are checked first, so the binary compare against a BCD limit is exact.
  function automatic logic bcd_ok(input logic [7:0] v, input logic [7:0] max);
    return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9) && (v <= max);
  endfunction
endpackage

// File: rtl/time_counter_bcd_counter.sv
// bcd_counter: two-digit packed-BCD counter wrapping at MAX, with sync load and carry out.
module bcd_counter
  import time_counter_pkg::*;
#(
  parameter logic [7:0] MAX = 8'h59
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       ld,
  input  logic [7:0] ld_val,
  output logic [7:0] q,
  output logic       co
);
  logic [7:0] q_d, q_q;
  assign co = en && !ld && (q_q == MAX);
  assign q  = q_q;
  always_comb q_d = ld ? ld_val : en ? ((q_q == MAX) ? 8'h00 : bcd_inc(q_q)) : q_q;
  always_ff @(posedge clk)
    if (!rst_n) q_q <= 8'h00;
    else        q_q <= q_d;
endmodule

// File: rtl/time_counter.sv
// time_counter: BCD 24h clock with prescaler, preset, hold and pulses.
// Optional hourly chime enabled by defining CHIME_EN.
module time_counter
  import time_counter_pkg::*;
#(
  parameter int TICK_DIV = 50000000
) (
  input  logic       CP,
  input  logic       _CR,
  input  logic       PE,
  input  logic [7:0] pre_hour,
  input  logic [7:0] pre_min,
  input  logic       hold,
  output logic [7:0] show_hour,
  output logic [7:0] show_min,
  output logic [7:0] show_sec,
  output logic       min_carry,
  output logic       day_wrap,
  output logic       set_err,
  output logic       chime
);
  localparam int PW = $clog2(TICK_DIV);
  logic [PW-1:0] pre_d, pre_q;
  logic pe_d, pe_q, min_carry_d, min_carry_q, day_wrap_d, day_wrap_q, set_err_d, set_err_q;
  logic tick, sec_en, sec_co, min_co, hour_co, hour_ok, min_ok;
  assign tick    = pre_q == PW'(TICK_DIV - 1);
  assign sec_en  = tick && !PE && !hold;
  assign hour_ok = bcd_ok(pre_hour, HOUR_MAX);
  assign min_ok  = bcd_ok(pre_min, MIN_MAX);
  always_comb begin
    pre_d       = (PE || (tick && !hold)) ? '0 : hold ? pre_q : pre_q + 1'b1;
    pe_d        = PE;
    min_carry_d = sec_co;
    day_wrap_d  = hour_co;
    set_err_d   = PE && !pe_q && !(hour_ok && min_ok);
  end
  always_ff @(posedge CP)
    if (!_CR) begin
      pre_q       <= '0;
      pe_q        <= 1'b0;
      min_carry_q <= 1'b0;
      day_wrap_q  <= 1'b0;
      set_err_q   <= 1'b0;
    end else begin
      pre_q       <= pre_d;
      pe_q        <= pe_d;
      min_carry_q <= min_carry_d;
      day_wrap_q  <= day_wrap_d;
      set_err_q   <= set_err_d;
    end
  bcd_counter #(.MAX(SEC_MAX)) u_sec (
    .clk(CP), .rst_n(_CR), .en(sec_en), .ld(PE), .ld_val(8'h00), .q(show_sec), .co(sec_co)
  );
  bcd_counter #(.MAX(MIN_MAX)) u_min (
    .clk(CP), .rst_n(_CR), .en(sec_co), .ld(PE), .ld_val(min_ok ? pre_min : 8'h00),
    .q(show_min), .co(min_co)
  );
  bcd_counter #(.MAX(HOUR_MAX)) u_hour (
    .clk(CP), .rst_n(_CR), .en(min_co), .ld(PE), .ld_val(hour_ok ? pre_hour : 8'h00),
    .q(show_hour), .co(hour_co)
  );
  assign min_carry = min_carry_q;
  assign day_wrap  = day_wrap_q;
  assign set_err   = set_err_q;
`ifdef CHIME_EN
  logic chime_d, chime_q;
  logic [7:0] sec_nx;
  // A minute rollover always lands on second 00, so only the next second needs predicting.
  always_comb begin
    sec_nx  = PE ? 8'h00 : sec_en ? (sec_co ? 8'h00 : bcd_inc(show_sec)) : show_sec;
    chime_d = (show_min == MIN_MAX) && (sec_nx >= CHIME_START);
  end
  always_ff @(posedge CP)
    if (!_CR) chime_q <= 1'b0;
    else      chime_q <= chime_d;
  assign chime = chime_q;
`else
  assign chime = 1'b0;
`endif
endmodule
